taxi_wheel_pulse_gen: RTL and testbench
=======================================

# taxi_wheel_pulse_gen

Wheel-sensor emulator for the taxi meter: turns the meter's speed/pause/stop mode inputs into the `wheel_clk` pulse train that the distance/low-speed-time counter consumes. It also keeps a golden pulse count and reference distance, so benches and on-board self-test can cross-check the meter's `distance` output. It sits between the mode-control logic (buttons/switches) and the meter counter, on the same `clk`.

## Interface

- `HIGH_HALF`, default 2: clk cycles per wheel_clk half-period in high-speed mode (≥1).
- `LOW_HALF`, default 8: clk cycles per wheel_clk half-period in low-speed mode (≥1).

- `clk` input 1: system clock; all logic on rising edge.
- `rst` input 1: synchronous, active-high reset.
- `high_speed` input 1: high-speed mode request.
- `low_speed` input 1: low-speed mode request.
- `pause_state` input 1: meter paused; wheel held still.
- `stop_state` input 1: trip ended; immediate stop and clear (level, synchronous).
- `wheel_clk` output 1: generated wheel pulse train, registered.
- `speed_state` output 2: current FSM state (0 IDLE, 1 LOW, 2 HIGH, 3 PAUSE).
- `pulse_count` output 32: rising edges of wheel_clk emitted since last clear; wraps modulo 2^32.
- `ref_distance` output 32: reference metres; +7 per 10 wheel pulses; wraps modulo 2^32.

## Operation

- Mode decode, priority: `stop_state` > `pause_state` > `high_speed` > `low_speed` > none (IDLE). If both speed inputs are high, HIGH wins.
- FSM states: IDLE, LOW, HIGH, PAUSE.
- Running states (LOW/HIGH): `wheel_clk` is high for HALF cycles, then low for HALF cycles. HALF = `HIGH_HALF` or `LOW_HALF`, latched at period start. Each period starts with a rising edge.
- Period boundary is the last cycle of the low phase. The decoded mode is re-evaluated only at a boundary:
  - same speed: next period starts, with no gap.
  - other speed: next period starts at the new HALF.
  - pause: go to PAUSE.
  - none: go to IDLE.
  - Mode changes mid-period never truncate or stretch a pulse.
- IDLE/PAUSE: `wheel_clk`=0 and counts held. The mode is evaluated every cycle. LOW/HIGH requested → rising edge at that same clk edge, new period starts.
- `stop_state`=1 (any state, any phase) at a clk edge:
  - `wheel_clk`←0, state←IDLE.
  - `pulse_count`, `ref_distance`, the internal mod-10 sub-counter and the half-period counter all ←0.
  - The block is held in this condition while `stop_state` stays high.
- Counting: on each emitted rising edge, `pulse_count`+1 and sub-counter+1. When the sub-counter reaches 10, it ←0 and `ref_distance`+7 in the same cycle.
- `rst` has the same effect as `stop_state` and overrides every input.
- Half-period counter: 16 bits, down-counter reloaded with HALF−1 at each phase start.

## Timing

- Reset values: `wheel_clk`=0, `speed_state`=0 (IDLE), `pulse_count`=0, `ref_distance`=0.
- All outputs are registered. There is no combinational input→output path.
- Start latency: a speed request sampled at edge N in IDLE/PAUSE gives `wheel_clk`=1 after edge N. `pulse_count` increments after the same edge N.
- Steady state: the period is exactly 2·HALF cycles; the high phase is HALF cycles.
- The `ref_distance` update is coincident with the 10th rising edge of `wheel_clk` (same register update).
- Stop latency: one edge. The cycle after `stop_state` is sampled high, all outputs are at their reset values.
- Release of `stop_state` with a speed input high: the first rising edge of `wheel_clk` occurs at the first edge sampling `stop_state`=0.
- HALF=1 is legal: the waveform is 1010…, and boundaries are evaluated every 2 cycles.

## Test plan

- Reset: hold `rst`=1 for 3 cycles with `high_speed`=1 → `wheel_clk`=0, `speed_state`=0, counts 0 throughout. Release `rst` → first rising edge on the next edge.
- High run: `high_speed`=1, default params, 80 cycles → `wheel_clk` follows 1100 repeating. After 20 periods, `pulse_count`=20 and `ref_distance`=14.
- Priority and switch:
  - `high_speed`=`low_speed`=1 → 4-cycle period.
  - Drop `high_speed` at the 2nd cycle of a high phase → current period finishes in 4 cycles, then a 16-cycle period (8 high, 8 low).
- Pause: assert `pause_state` during a high phase of LOW mode → the pulse completes its full 8+8 cycles, then `wheel_clk`=0 and `speed_state`=3 with counts frozen. Release → rising edge on the first edge sampling `pause_state`=0.
- Stop mid-pulse: after 13 pulses (`ref_distance`=7), assert `stop_state` during a high phase → the next cycle shows `wheel_clk`=0 and both counts 0. Release → 10 new pulses give `ref_distance`=7, proving the sub-counter was cleared.
- Wrap: force `pulse_count`=32'hFFFF_FFFF via backdoor and emit one pulse → `pulse_count`=0.

Source files
------------

// File: rtl/taxi_wheel_pulse_gen.sv
// Wheel-sensor emulator for the taxi meter.
// Generates wheel_clk from mode inputs and keeps golden pulse/distance counts.
module taxi_wheel_pulse_gen #(
  parameter int HIGH_HALF = 2,
  parameter int LOW_HALF  = 8
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        high_speed,
  input  logic        low_speed,
  input  logic        pause_state,
  input  logic        stop_state,
  output logic        wheel_clk,
  output logic [1:0]  speed_state,
  output logic [31:0] pulse_count,
  output logic [31:0] ref_distance
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    LOW   = 2'd1,
    HIGH  = 2'd2,
    PAUSE = 2'd3
  } state_t;

  localparam logic [15:0] HI_RLD = 16'(HIGH_HALF - 1);
  localparam logic [15:0] LO_RLD = 16'(LOW_HALF - 1);

  state_t      state, state_n;
  logic        wheel_n;
  logic [15:0] cnt, cnt_n;
  logic [15:0] rld, rld_n;
  logic [3:0]  sub, sub_n;
  logic [31:0] pc_n, ref_n;
  logic        eval, start;

  assign speed_state = state;

  // Next-state: phase countdown, boundary mode decode, pulse counting, stop clear
  always_comb begin
    state_n = state;
    wheel_n = wheel_clk;
    cnt_n   = cnt;
    rld_n   = rld;
    sub_n   = sub;
    pc_n    = pulse_count;
    ref_n   = ref_distance;
    eval    = 1'b0;
    start   = 1'b0;

    unique case (state)
      LOW, HIGH: begin
        if (cnt != 16'd0) begin
          cnt_n = cnt - 16'd1;
        end else if (wheel_clk) begin
          wheel_n = 1'b0;
          cnt_n   = rld;
        end else begin
          eval = 1'b1;
        end
      end
      IDLE, PAUSE: eval = 1'b1;
    endcase

    if (eval) begin
      if (pause_state) begin
        state_n = PAUSE;
      end else if (high_speed || low_speed) begin
        start = 1'b1;
      end else begin
        state_n = IDLE;
      end
    end

    if (start) begin
      state_n = high_speed ? HIGH : LOW;
      rld_n   = high_speed ? HI_RLD : LO_RLD;
      cnt_n   = rld_n;
      wheel_n = 1'b1;
      pc_n    = pulse_count + 32'd1;
      if (sub == 4'd9) begin
        sub_n = 4'd0;
        ref_n = ref_distance + 32'd7;
      end else begin
        sub_n = sub + 4'd1;
      end
    end

    if (stop_state) begin
      state_n = IDLE;
      wheel_n = 1'b0;
      cnt_n   = 16'd0;
      rld_n   = 16'd0;
      sub_n   = 4'd0;
      pc_n    = 32'd0;
      ref_n   = 32'd0;
    end
  end

  // State and output registers
  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= IDLE;
      wheel_clk    <= 1'b0;
      cnt          <= 16'd0;
      rld          <= 16'd0;
      sub          <= 4'd0;
      pulse_count  <= 32'd0;
      ref_distance <= 32'd0;
    end else begin
      state        <= state_n;
      wheel_clk    <= wheel_n;
      cnt          <= cnt_n;
      rld          <= rld_n;
      sub          <= sub_n;
      pulse_count  <= pc_n;
      ref_distance <= ref_n;
    end
  end

endmodule

// File: tb/tb_taxi_wheel_pulse_gen.sv
// Bench for taxi_wheel_pulse_gen.
// Directed plan plus random modes, checked against a period-position model.
module tb_taxi_wheel_pulse_gen;

  localparam int HH = 2;
  localparam int LH = 8;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        high_speed = 1'b0;
  logic        low_speed = 1'b0;
  logic        pause_state = 1'b0;
  logic        stop_state = 1'b0;
  logic        wheel_clk;
  logic [1:0]  speed_state;
  logic [31:0] pulse_count;
  logic [31:0] ref_distance;

  int n_cmp = 0;
  int n_bad = 0;

  // model: mode 0 idle,1 low,2 high,3 pause; pos = cycle within period
  int          m_mode = 0;
  int          m_half = 0;
  int          m_pos = 0;
  int          m_sub = 0;
  logic        m_wheel = 1'b0;
  logic [31:0] m_pc = '0;
  logic [31:0] m_ref = '0;

  taxi_wheel_pulse_gen #(.HIGH_HALF(HH), .LOW_HALF(LH)) dut (
    .clk(clk),
    .rst(rst),
    .high_speed(high_speed),
    .low_speed(low_speed),
    .pause_state(pause_state),
    .stop_state(stop_state),
    .wheel_clk(wheel_clk),
    .speed_state(speed_state),
    .pulse_count(pulse_count),
    .ref_distance(ref_distance)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
    n_cmp++;
    assert (got === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic model_step();
    bit running, at_bound;
    running  = (m_mode == 1) || (m_mode == 2);
    at_bound = running && (m_pos == 2 * m_half - 1);
    if (rst || stop_state) begin
      m_mode = 0; m_pos = 0; m_half = 0; m_sub = 0;
      m_pc = '0; m_ref = '0;
    end else if (running && !at_bound) begin
      m_pos++;
    end else if (pause_state) begin
      m_mode = 3;
    end else if (high_speed || low_speed) begin
      m_mode = high_speed ? 2 : 1;
      m_half = high_speed ? HH : LH;
      m_pos  = 0;
      m_pc   = m_pc + 1;
      m_sub++;
      if (m_sub == 10) begin
        m_sub = 0;
        m_ref = m_ref + 7;
      end
    end else begin
      m_mode = 0;
    end
    m_wheel = ((m_mode == 1) || (m_mode == 2)) && (m_pos < m_half);
  endtask

  task automatic tick();
    @(posedge clk);
    model_step();
    #1;
    check("wheel_clk", 32'(wheel_clk), 32'(m_wheel));
    check("speed_state", 32'(speed_state), 32'(m_mode));
    check("pulse_count", pulse_count, m_pc);
    check("ref_distance", ref_distance, m_ref);
  endtask

  initial begin
    int n;
    #1;
    // reset held with high_speed requested
    high_speed = 1'b1;
    repeat (3) tick();
    rst = 1'b0;
    tick();
    check("first_rise", 32'(wheel_clk), 32'd1);

    // high run: 80 cycles = 20 periods
    repeat (79) tick();
    check("high_run_pc", pulse_count, 32'd20);
    check("high_run_ref", ref_distance, 32'd14);

    // both speeds: HIGH wins
    low_speed = 1'b1;
    repeat (8) tick();
    n = 0;
    while (!(m_mode == 2 && m_pos == 1) && n < 20) begin
      tick(); n++;
    end
    high_speed = 1'b0;
    n = 0;
    do begin
      tick(); n++;
    end while (wheel_clk !== 1'b1 && n < 40);
    check("switch_rise_delay", 32'(n), 32'd3);
    check("switch_to_low", 32'(speed_state), 32'd1);

    // pause during high phase of LOW mode
    n = 0;
    while (!(m_mode == 1 && m_pos == 2) && n < 40) begin
      tick(); n++;
    end
    pause_state = 1'b1;
    n = 0;
    do begin
      tick(); n++;
    end while (speed_state !== 2'd3 && n < 40);
    check("pause_delay", 32'(n), 32'd14);
    check("pause_wheel", 32'(wheel_clk), 32'd0);
    repeat (5) tick();
    pause_state = 1'b0;
    tick();
    check("unpause_rise", 32'(wheel_clk), 32'd1);

    // stop mid-pulse after 13 pulses
    stop_state = 1'b1;
    tick();
    stop_state = 1'b0;
    low_speed  = 1'b0;
    high_speed = 1'b1;
    n = 0;
    while (pulse_count !== 32'd13 && n < 200) begin
      tick(); n++;
    end
    check("pc13_ref", ref_distance, 32'd7);
    check("pc13_high", 32'(wheel_clk), 32'd1);
    stop_state = 1'b1;
    tick();
    check("stop_wheel", 32'(wheel_clk), 32'd0);
    check("stop_pc", pulse_count, 32'd0);
    check("stop_ref", ref_distance, 32'd0);
    stop_state = 1'b0;
    n = 0;
    while (pulse_count !== 32'd10 && n < 200) begin
      tick(); n++;
    end
    check("after_stop_ref", ref_distance, 32'd7);

    // wrap of pulse_count
    high_speed = 1'b0;
    stop_state = 1'b1;
    tick();
    stop_state = 1'b0;
    tick();
    @(negedge clk);
    force dut.pulse_count = 32'hFFFF_FFFF;
    m_pc = 32'hFFFF_FFFF;
    tick();
    @(negedge clk);
    release dut.pulse_count;
    high_speed = 1'b1;
    tick();
    check("wrap_pc", pulse_count, 32'd0);

    // randomized modes
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 5) == 0) begin
        high_speed  = 1'($urandom_range(0, 1));
        low_speed   = 1'($urandom_range(0, 1));
        pause_state = ($urandom_range(0, 4) == 0);
      end
      stop_state = ($urandom_range(0, 59) == 0);
      rst        = ($urandom_range(0, 199) == 0);
      tick();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
